permutation_sequencer: RTL and testbench
========================================

// Module: permutation_sequencer
// PURPOSE
//  Sequences the ASCON permutation datapath (constant addition -> substitution -> diffusion) over p^a or p^b rounds.
//  Accepts a start request, drives the round index, state-register enable and input-select for the round datapath.
//  Signals completion with a valid/ready handshake. Sits between the mode FSM and the round datapath.
// PARAMETERS
//  NB_ROUNDS_A  12  rounds of p^a; also the total constant-table length
//  NB_ROUNDS_B  6   rounds of p^b; must be <= NB_ROUNDS_A
//  UNROLL       1   rounds computed per clock; legal values divide both NB_ROUNDS_A and NB_ROUNDS_B (1,2,3,6)
// PORTS
//  clock_i       in   1  system clock, rising edge
//  reset_i       in   1  asynchronous, active-high reset
//  start_i       in   1  request a permutation; accepted when start_i & ready_o
//  mode_i        in   1  0: p^a (NB_ROUNDS_A), 1: p^b (NB_ROUNDS_B); sampled on acceptance only
//  ready_o       out  1  sequencer idle, can accept start_i
//  sel_init_o    out  1  state register loads the external input state (1) or the round output (0)
//  en_state_o    out  1  state register write enable
//  round_o       out  4  index of first round processed this cycle (datapath uses round_o+k, k<UNROLL)
//  valid_o       out  1  permuted state is stable in the state register
//  ready_i       in   1  consumer has taken the result
//  abort_i       in   1  only with PERM_ABORT_EN: cancel current operation
// BEHAVIOUR
//  - Reset (async, any time): state IDLE, round_o=0, valid_o=0, ready_o=1, en_state_o=0, sel_init_o=0.
//  - FSM type_perm_state: IDLE, RUN, DONE.
//  - IDLE: ready_o=1. If start_i: sel_init_o=1, en_state_o=1 (Mealy; input state loaded this edge),
//    round_o <= NB_ROUNDS_A-nb (nb=rounds of selected mode, i.e. 0 for p^a, 6 for p^b), go RUN.
//  - RUN: en_state_o=1, sel_init_o=0, ready_o=0. Each cycle round_o <= round_o+UNROLL.
//    When round_o+UNROLL == NB_ROUNDS_A: go DONE (last round written this edge), round_o held.
//  - RUN lasts exactly nb/UNROLL cycles: p^a UNROLL=1 -> 12 cycles, p^b -> 6 cycles.
//  - DONE: valid_o=1, en_state_o=0, ready_o=0. Held until ready_i=1; then IDLE next edge, round_o <= 0.
//  - Total latency accept->valid_o: nb/UNROLL+1 edges.
//  - start_i in RUN or DONE ignored (ready_o=0); not queued. start_i & ready_i in DONE: DONE->IDLE only.
//  - mode_i changes after acceptance have no effect on the current run.
//  - round_o never exceeds NB_ROUNDS_A-1 while en_state_o=1; no wrap-around.
//  - Reset mid-RUN: returns to IDLE immediately; state register contents undefined for consumers.
// CONFIGURATION
//  PERM_ABORT_EN defined: port abort_i exists; abort_i=1 in any state -> IDLE next edge, round_o=0,
//    valid_o=0, en_state_o forced 0 in that cycle; abort has priority over start_i and ready_i.
//  PERM_ABORT_EN undefined: no abort_i port; an operation, once accepted, always runs to DONE.
// STRUCTURE
//  - ascon_pack: typedef enum logic[1:0] type_perm_state {IDLE,RUN,DONE}; typedef logic[3:0] type_round;
//    localparams for NB_ROUNDS_A/NB_ROUNDS_B defaults shared with the constant-addition layer.
//  - Sub-module round_counter: loadable up-counter (load value, step UNROLL, terminal flag);
//    FSM and output decode stay in permutation_sequencer.
//  - Elaboration-time check: UNROLL divides both round counts, NB_ROUNDS_B <= NB_ROUNDS_A.
// TESTING
//  1 Reset mid-RUN (round_o=5) -> all outputs at reset values same cycle, ready_o=1.
//  2 start_i=1, mode_i=0, UNROLL=1 -> sel_init_o pulse 1 cycle, round_o 0..11 over 12 en_state_o cycles, valid_o on 13th edge.
//  3 start_i=1, mode_i=1 -> round_o 6..11, 6 RUN cycles, valid_o after 7 edges; mode_i toggled mid-run has no effect.
//  4 DONE with ready_i=0 for 10 cycles -> valid_o stays 1, en_state_o=0, start_i ignored; ready_i=1 -> IDLE next edge.
//  5 UNROLL=3, mode_i=0 -> round_o 0,3,6,9; 4 RUN cycles; mode_i=1 -> round_o 6,9.
//  6 PERM_ABORT_EN: abort_i at round_o=4 together with start_i -> IDLE, round_o=0, valid_o never asserted.

Source files
------------

// File: rtl/permutation_sequencer_pkg.sv
// permutation_sequencer_pkg: FSM states, round index type and default round counts shared with the constant-addition layer.
package permutation_sequencer_pkg;
  localparam int NB_ROUNDS_A_DEF = 12;
  localparam int NB_ROUNDS_B_DEF = 6;
  typedef enum logic [1:0] {IDLE, RUN, DONE} type_perm_state;
  typedef logic [3:0] type_round;
endpackage

// File: rtl/permutation_sequencer_round_counter.sv
// permutation_sequencer_round_counter: loadable round up-counter stepping by STEP, flags the last step before TERM.
module permutation_sequencer_round_counter
  import permutation_sequencer_pkg::*;
#(
  parameter int STEP = 1,
  parameter int TERM = NB_ROUNDS_A_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      inc,
  input  logic      clr,
  input  type_round load_val,
  output type_round count,
  output logic      last
);
  assign last = int'(count) + STEP == TERM;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (load) count <= load_val;
    else if (inc) count <= count + type_round'(STEP);
endmodule

// File: rtl/permutation_sequencer.sv
// permutation_sequencer: drives round index, state enable and input select of the ASCON round datapath for p^a/p^b.
// Optional abort_i port enabled by defining PERM_ABORT_EN.
module permutation_sequencer
  import permutation_sequencer_pkg::*;
#(
  parameter int NB_ROUNDS_A = NB_ROUNDS_A_DEF,
  parameter int NB_ROUNDS_B = NB_ROUNDS_B_DEF,
  parameter int UNROLL      = 1
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      start_i,
  input  logic      mode_i,
  output logic      ready_o,
  output logic      sel_init_o,
  output logic      en_state_o,
  output type_round round_o,
  output logic      valid_o,
  input  logic      ready_i
`ifdef PERM_ABORT_EN
  ,
  input  logic      abort_i
`endif
);
  if (UNROLL < 1 || NB_ROUNDS_A % UNROLL != 0 || NB_ROUNDS_B % UNROLL != 0 ||
      NB_ROUNDS_B > NB_ROUNDS_A || NB_ROUNDS_A > 16) begin : g_bad_cfg
    $error("permutation_sequencer: illegal NB_ROUNDS_A/NB_ROUNDS_B/UNROLL combination");
  end
  type_perm_state state, state_d;
  logic abort, accept, last;
  type_round load_val;
`ifdef PERM_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif
  assign accept   = state == IDLE && start_i && !abort;
  // p^b uses the tail of the constant table, so it starts at NB_ROUNDS_A-NB_ROUNDS_B
  assign load_val = mode_i ? type_round'(NB_ROUNDS_A - NB_ROUNDS_B) : '0;
  permutation_sequencer_round_counter #(.STEP(UNROLL), .TERM(NB_ROUNDS_A)) u_round_counter (
    .clk      (clock_i),
    .rst      (reset_i),
    .load     (accept),
    .inc      (state == RUN && !last && !abort),
    .clr      (abort || (state == DONE && ready_i)),
    .load_val (load_val),
    .count    (round_o),
    .last     (last)
  );
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) state <= IDLE;
    else state <= state_d;
  always_comb begin
    ready_o    = state == IDLE;
    valid_o    = state == DONE;
    sel_init_o = accept;
    en_state_o = accept || (state == RUN && !abort);
    state_d    = abort                      ? IDLE :
                 accept                     ? RUN  :
                 (state == RUN && last)     ? DONE :
                 (state == DONE && ready_i) ? IDLE : state;
  end
endmodule

// File: tb/tb_permutation_sequencer.sv
// tb_permutation_sequencer: scoreboard bench for permutation_sequencer (UNROLL=1 and UNROLL=3 instances).
module tb_permutation_sequencer;
  typedef struct {int first; int last; int n;} run_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic a_start, a_mode, a_ready_i, a_ready_o, a_sel, a_en, a_valid;
  logic [3:0] a_round;
  logic b_start, b_mode, b_ready_i, b_ready_o, b_sel, b_en, b_valid;
  logic [3:0] b_round;
`ifdef PERM_ABORT_EN
  logic a_abort, b_abort;
`endif
  int checks = 0, passed = 0;
  run_t exp_q[$];
  run_t m_exp;
  bit active = 0;
  int m_first = 0, m_last = 0, m_n = 0;

  permutation_sequencer dut_a (
    .clock_i(clk), .reset_i(rst), .start_i(a_start), .mode_i(a_mode), .ready_o(a_ready_o),
    .sel_init_o(a_sel), .en_state_o(a_en), .round_o(a_round), .valid_o(a_valid), .ready_i(a_ready_i)
`ifdef PERM_ABORT_EN
    , .abort_i(a_abort)
`endif
  );
  permutation_sequencer #(.UNROLL(3)) dut_b (
    .clock_i(clk), .reset_i(rst), .start_i(b_start), .mode_i(b_mode), .ready_o(b_ready_o),
    .sel_init_o(b_sel), .en_state_o(b_en), .round_o(b_round), .valid_o(b_valid), .ready_i(b_ready_i)
`ifdef PERM_ABORT_EN
    , .abort_i(b_abort)
`endif
  );

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  // monitor: collects each run of dut_a and compares it against the scoreboard when valid_o rises
  always @(negedge clk) begin
    if (rst) active = 0;
    else begin
      if (a_sel) begin
        active = 1;
        m_n = 0;
      end else if (a_en && active) begin
        if (m_n == 0) m_first = int'(a_round);
        m_last = int'(a_round);
        m_n++;
      end
      if (a_en) chk("round_in_range", int'(a_round <= 4'd11), 1);
      if (a_valid && active) begin
        active = 0;
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          m_exp = exp_q.pop_front();
          chk("run_first_round", m_first, m_exp.first);
          chk("run_last_round", m_last, m_exp.last);
          chk("run_cycles", m_n, m_exp.n);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = a_valid;
    end
  endtask

  task automatic wait_a_round(input int r, output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = a_en && int'(a_round) == r;
    end
  endtask

  task automatic chk_a_reset(string tag);
    chk({tag, "_ready_o"}, int'(a_ready_o), 1);
    chk({tag, "_valid_o"}, int'(a_valid), 0);
    chk({tag, "_en_state_o"}, int'(a_en), 0);
    chk({tag, "_sel_init_o"}, int'(a_sel), 0);
    chk({tag, "_round_o"}, int'(a_round), 0);
  endtask

  task automatic run_b(input logic mode, input int first, input int n);
    tick;
    b_start = 1;
    b_mode  = mode;
    tick;
    b_start = 0;
    b_mode  = ~mode;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("b_en_state_o", int'(b_en), 1);
      chk("b_round_o", int'(b_round), first + 3 * i);
      chk("b_valid_o_early", int'(b_valid), 0);
    end
    @(negedge clk);
    chk("b_valid_o", int'(b_valid), 1);
    chk("b_en_state_o_done", int'(b_en), 0);
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, seen;
    rst = 1;
    a_start = 0; a_mode = 0; a_ready_i = 0;
    b_start = 0; b_mode = 0; b_ready_i = 1;
`ifdef PERM_ABORT_EN
    a_abort = 0; b_abort = 0;
`endif
    repeat (2) @(negedge clk);
    chk_a_reset("reset");
    rst = 0;
    tick;
    // p^a: 12 RUN cycles, rounds 0..11, then DONE held while the consumer stalls
    exp_q.push_back('{0, 11, 12});
    a_start = 1;
    a_mode  = 0;
    @(negedge clk);
    chk("accept_sel_init_o", int'(a_sel), 1);
    chk("accept_en_state_o", int'(a_en), 1);
    chk("accept_ready_o", int'(a_ready_o), 1);
    tick;
    a_start = 0;
    @(negedge clk);
    chk("run_sel_init_o", int'(a_sel), 0);
    chk("run_ready_o", int'(a_ready_o), 0);
    wait_a_valid(ok);
    chk("pa_valid_seen", int'(ok), 1);
    a_start = 1;
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid_o", int'(a_valid), 1);
      chk("stall_en_state_o", int'(a_en), 0);
      chk("stall_ready_o", int'(a_ready_o), 0);
    end
    a_ready_i = 1;
    @(posedge clk);
    #1 a_start = 0;
    #1;
    chk("release_ready_o", int'(a_ready_o), 1);
    chk("release_valid_o", int'(a_valid), 0);
    chk("release_round_o", int'(a_round), 0);
    chk("release_en_state_o", int'(a_en), 0);
    // p^b with mode_i toggling mid-run
    tick;
    exp_q.push_back('{6, 11, 6});
    a_start = 1;
    a_mode  = 1;
    tick;
    a_start = 0;
    a_mode  = 0;
    tick;
    a_mode = 1;
    tick;
    a_mode = 0;
    wait_a_valid(ok);
    chk("pb_valid_seen", int'(ok), 1);
    @(negedge clk);
    chk("pb_back_idle", int'(a_ready_o), 1);
    // asynchronous reset in the middle of a p^a run
    tick;
    a_start = 1;
    a_mode  = 0;
    tick;
    a_start = 0;
    wait_a_round(5, ok);
    chk("reached_round5", int'(ok), 1);
    #1 rst = 1;
    #1 chk_a_reset("midrun_reset");
    #1 rst = 0;
    repeat (3) @(negedge clk);
    chk("after_reset_valid_o", int'(a_valid), 0);
    // UNROLL=3 instance
    run_b(1'b0, 0, 4);
    run_b(1'b1, 6, 2);
`ifdef PERM_ABORT_EN
    tick;
    a_start = 1;
    a_mode  = 0;
    tick;
    a_start = 0;
    wait_a_round(4, ok);
    chk("reached_round4", int'(ok), 1);
    a_abort = 1;
    a_start = 1;
    #1;
    chk("abort_en_state_o", int'(a_en), 0);
    chk("abort_sel_init_o", int'(a_sel), 0);
    @(posedge clk);
    #1 a_abort = 0;
    a_start = 0;
    #1;
    chk("abort_ready_o", int'(a_ready_o), 1);
    chk("abort_round_o", int'(a_round), 0);
    seen = 0;
    repeat (16) begin
      @(negedge clk);
      seen |= a_valid;
    end
    chk("abort_no_valid", int'(seen), 0);
`endif
    seen = 0;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
